// File: rtl/fb_scanout_dma_if.sv
// Avalon-MM burst read channel between the scan-out DMA (master) and the
// f2h_sdram port (slave).
interface fb_scanout_dma_if #(
  parameter int ADDR_WIDTH = 29,
  parameter int DATA_WIDTH = 64
);
  logic [ADDR_WIDTH-1:0] address;
  logic [7:0]            burstcount;
  logic                  read;
  logic                  waitrequest;
  logic [DATA_WIDTH-1:0] readdata;
  logic                  readdatavalid;

  modport master (
    output address, burstcount, read,
    input  waitrequest, readdata, readdatavalid
  );

  modport slave (
    input  address, burstcount, read,
    output waitrequest, readdata, readdatavalid
  );
endinterface

// File: rtl/fb_scanout_dma.sv
// Framebuffer scan-out reader: one-burst-at-a-time Avalon fetch into a word FIFO,
// unpacked LSB-first into RGB888. States: IDLE wait space | REQ hold read | DATA store beats | DRAIN discard beats.
module fb_scanout_dma #(
  parameter int          ADDR_WIDTH   = 29,
  parameter int          DATA_WIDTH   = 64,
  parameter int          BURST_LEN    = 16,
  parameter int          FIFO_DEPTH   = 256,
  parameter int          FRAME_PIXELS = 307200,
  parameter int unsigned BUF0_BASE    = 0,
  parameter int unsigned BUF1_BASE    = 'h100000
) (
  input  logic             clock,
  input  logic             reset,
  fb_scanout_dma_if.master avm,
  input  logic             buffer_sel,
  input  logic             bpp16,
  input  logic             frame_start,
  input  logic             pixel_req,
  output logic [23:0]      pixel,
  output logic             pixel_valid,
  output logic             active_buffer,
  output logic             swap_done,
  output logic             underflow
);
  localparam int PPW32   = DATA_WIDTH / 32;
  localparam int PPW16   = DATA_WIDTH / 16;
  localparam int WORDS32 = FRAME_PIXELS / PPW32;
  localparam int WORDS16 = FRAME_PIXELS / PPW16;
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int IDX_W   = $clog2(PPW16);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_DATA, S_DRAIN} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           words_left_q, words_left_d;
  logic [7:0]            burst_q, burst_d;
  logic [7:0]            beats_q, beats_d;
  logic                  active_q, active_d, swap_q, swap_d;
  logic                  bpp16_q, bpp16_d, underflow_q, underflow_d;
  logic [DATA_WIDTH-1:0] word_q, word_d;
  logic                  word_valid_q, word_valid_d;
  logic [IDX_W-1:0]      idx_q, idx_d, idx_last;
  logic [23:0]           pixel_q, pixel_d;
  logic                  pixel_valid_q, pixel_valid_d;

  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]      count_q;
  logic                  fifo_wr, fifo_pop;
  logic [DATA_WIDTH-1:0] fifo_head;

  function automatic logic [23:0] unpack(input logic [DATA_WIDTH-1:0] w,
                                         input logic [IDX_W-1:0] k, input logic m16);
    logic [31:0] p32;
    logic [15:0] p16;
    p32 = 32'(w >> (32 * k));
    p16 = 16'(w >> (16 * k));
    if (m16) return {p16[15:11], p16[15:13], p16[10:5], p16[10:9], p16[4:0], p16[4:2]};
    return p32[23:0];
  endfunction

  assign fifo_head = mem_q[rd_ptr_q];

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    words_left_d = words_left_q;
    burst_d      = burst_q;
    beats_d      = beats_q;
    fifo_wr      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!frame_start && words_left_q != 0 &&
            (32'(count_q) + 32'(BURST_LEN)) <= 32'(FIFO_DEPTH)) begin
          burst_d = (words_left_q < 32'(BURST_LEN)) ? words_left_q[7:0] : 8'(BURST_LEN);
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (!avm.waitrequest) begin
          beats_d      = burst_q;
          addr_d       = addr_q + ADDR_WIDTH'(burst_q);
          words_left_d = words_left_q - 32'(burst_q);
          state_d      = frame_start ? S_DRAIN : S_DATA;
        end else if (frame_start) begin
          state_d = S_IDLE;
        end
      end
      S_DATA: begin
        if (avm.readdatavalid) begin
          fifo_wr = !frame_start;
          beats_d = beats_q - 8'd1;
        end
        if (avm.readdatavalid && beats_q == 8'd1) state_d = S_IDLE;
        else if (frame_start)                     state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (avm.readdatavalid) begin
          beats_d = beats_q - 8'd1;
          if (beats_q == 8'd1) state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // New frame state overrides whatever the fetch step computed.
    if (frame_start) begin
      addr_d       = buffer_sel ? ADDR_WIDTH'(BUF1_BASE) : ADDR_WIDTH'(BUF0_BASE);
      words_left_d = bpp16 ? 32'(WORDS16) : 32'(WORDS32);
    end
  end

  always_comb begin
    word_d        = word_q;
    word_valid_d  = word_valid_q;
    idx_d         = idx_q;
    pixel_d       = pixel_q;
    pixel_valid_d = 1'b0;
    underflow_d   = underflow_q;
    bpp16_d       = bpp16_q;
    active_d      = active_q;
    swap_d        = 1'b0;
    fifo_pop      = 1'b0;
    idx_last      = bpp16_q ? IDX_W'(PPW16 - 1) : IDX_W'(PPW32 - 1);
    if (frame_start) begin
      word_valid_d = 1'b0;
      idx_d        = '0;
      pixel_d      = '0;
      underflow_d  = 1'b0;
      bpp16_d      = bpp16;
      active_d     = buffer_sel;
      swap_d       = buffer_sel != active_q;
    end else if (pixel_req) begin
      if (word_valid_q) begin
        pixel_d       = unpack(word_q, idx_q, bpp16_q);
        pixel_valid_d = 1'b1;
        if (idx_q == idx_last) word_valid_d = 1'b0;
        else                   idx_d = idx_q + IDX_W'(1);
      end else if (count_q != '0) begin
        fifo_pop      = 1'b1;
        word_d        = fifo_head;
        pixel_d       = unpack(fifo_head, '0, bpp16_q);
        pixel_valid_d = 1'b1;
        idx_d         = IDX_W'(1);
        word_valid_d  = idx_last != '0;
      end else begin
        pixel_d     = '0;
        underflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= S_IDLE;
      addr_q        <= '0;
      words_left_q  <= '0;
      burst_q       <= '0;
      beats_q       <= '0;
      active_q      <= 1'b0;
      swap_q        <= 1'b0;
      bpp16_q       <= 1'b0;
      underflow_q   <= 1'b0;
      word_q        <= '0;
      word_valid_q  <= 1'b0;
      idx_q         <= '0;
      pixel_q       <= '0;
      pixel_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      words_left_q  <= words_left_d;
      burst_q       <= burst_d;
      beats_q       <= beats_d;
      active_q      <= active_d;
      swap_q        <= swap_d;
      bpp16_q       <= bpp16_d;
      underflow_q   <= underflow_d;
      word_q        <= word_d;
      word_valid_q  <= word_valid_d;
      idx_q         <= idx_d;
      pixel_q       <= pixel_d;
      pixel_valid_q <= pixel_valid_d;
    end
  end

  always_ff @(posedge clock) begin
    if (reset || frame_start) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (fifo_wr)  wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (fifo_pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_q + CNT_W'(fifo_wr) - CNT_W'(fifo_pop);
    end
  end

  always_ff @(posedge clock) begin
    if (fifo_wr) mem_q[wr_ptr_q] <= avm.readdata;
  end

  assign avm.read       = state_q == S_REQ;
  assign avm.address    = addr_q;
  assign avm.burstcount = burst_q;
  assign pixel          = pixel_q;
  assign pixel_valid    = pixel_valid_q;
  assign active_buffer  = active_q;
  assign swap_done      = swap_q;
  assign underflow      = underflow_q;
endmodule

// File: tb/tb_fb_scanout_dma.sv
// Directed bench for fb_scanout_dma with a cycle-level Avalon burst slave model.
module tb_fb_scanout_dma;
  logic        clk = 1'b0;
  logic        rst;
  logic        buffer_sel, bpp16, frame_start, pixel_req;
  logic [23:0] pixel;
  logic        pixel_valid, active_buffer, swap_done, underflow;

  fb_scanout_dma_if #(.ADDR_WIDTH(29), .DATA_WIDTH(64)) avm_if ();

  fb_scanout_dma #(
    .ADDR_WIDTH(29), .DATA_WIDTH(64), .BURST_LEN(16), .FIFO_DEPTH(32),
    .FRAME_PIXELS(40), .BUF0_BASE(0), .BUF1_BASE('h100000)
  ) dut (
    .clock(clk), .reset(rst), .avm(avm_if.master),
    .buffer_sel(buffer_sel), .bpp16(bpp16), .frame_start(frame_start),
    .pixel_req(pixel_req), .pixel(pixel), .pixel_valid(pixel_valid),
    .active_buffer(active_buffer), .swap_done(swap_done), .underflow(underflow)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_bad = 0;
  int cyc = 0, wait_cfg = 0, beat_stop = -1;
  bit data16 = 1'b0;
  int pend = 0, burst_beats = 0, beats_total = 0, last_beat_cyc = 0;
  int stall_n = 0, read_cycles = 0, stall_viol = 0;
  logic [28:0] beat_addr, req_addr0;
  logic [7:0]  req_bc0;
  logic [28:0] acc_addr[$];
  logic [7:0]  acc_bc[$];
  int          acc_cyc[$];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] data_of(input logic [28:0] a);
    if (data16) return 64'hF800_07E0_001F_FFFF;
    return {8'hA5, a[22:0], 1'b1, 8'h5A, a[22:0], 1'b0};
  endfunction

  // Slave: decisions made mid-cycle from registered DUT outputs.
  initial begin
    avm_if.waitrequest   = 1'b0;
    avm_if.readdatavalid = 1'b0;
    avm_if.readdata      = '0;
    forever begin
      @(negedge clk);
      cyc++;
      avm_if.readdatavalid = 1'b0;
      if (pend > 0 && burst_beats != beat_stop) begin
        avm_if.readdatavalid = 1'b1;
        avm_if.readdata      = data_of(beat_addr);
        beat_addr++;
        pend--;
        burst_beats++;
        beats_total++;
        last_beat_cyc = cyc;
      end
      avm_if.waitrequest = 1'b0;
      if (avm_if.read === 1'b1) begin
        if (stall_n == 0) begin
          req_addr0 = avm_if.address;
          req_bc0   = avm_if.burstcount;
        end else if (avm_if.address != req_addr0 || avm_if.burstcount != req_bc0) begin
          stall_viol++;
        end
        read_cycles++;
        if (stall_n < wait_cfg) begin
          avm_if.waitrequest = 1'b1;
          stall_n++;
        end else begin
          acc_addr.push_back(avm_if.address);
          acc_bc.push_back(avm_if.burstcount);
          acc_cyc.push_back(cyc);
          pend        = int'(avm_if.burstcount);
          beat_addr   = avm_if.address;
          burst_beats = 0;
          stall_n     = 0;
        end
      end else begin
        stall_n = 0;
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_frame(input logic sel, input logic m16);
    buffer_sel  = sel;
    bpp16       = m16;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
  endtask

  task automatic wait_beats(input int target, input string tag);
    for (int i = 0; i < 2000 && beats_total < target; i++) tick();
    chk(tag, 64'(beats_total >= target), 64'd1);
  endtask

  task automatic wait_acc(input int target, input string tag);
    for (int i = 0; i < 2000 && acc_addr.size() < target; i++) tick();
    chk(tag, 64'(acc_addr.size() >= target), 64'd1);
  endtask

  task automatic pop(input string tag, input logic [23:0] exp);
    pixel_req = 1'b1;
    tick();
    pixel_req = 1'b0;
    chk({tag, "_vld"}, 64'(pixel_valid), 64'd1);
    chk(tag, 64'(pixel), 64'(exp));
  endtask

  int n0, b0, rc0;

  initial begin
    rst = 1'b1; buffer_sel = 1'b0; bpp16 = 1'b0; frame_start = 1'b0; pixel_req = 1'b0;
    repeat (3) tick();
    chk("rst_read", 64'(avm_if.read), 64'd0);
    chk("rst_addr", 64'(avm_if.address), 64'd0);
    chk("rst_bc", 64'(avm_if.burstcount), 64'd0);
    chk("rst_pixel", 64'(pixel), 64'd0);
    chk("rst_pvld", 64'(pixel_valid), 64'd0);
    chk("rst_active", 64'(active_buffer), 64'd0);
    chk("rst_swap", 64'(swap_done), 64'd0);
    chk("rst_uflow", 64'(underflow), 64'd0);
    rst = 1'b0;
    repeat (10) tick();
    chk("no_fetch_before_frame", 64'(acc_addr.size()), 64'd0);

    // 32 bpp, 20 words: bursts of 16 then 4; mid-frame buffer_sel ignored
    start_frame(1'b0, 1'b0);
    chk("a_swap", 64'(swap_done), 64'd0);
    buffer_sel = 1'b1;
    wait_beats(20, "a_beats_timeout");
    repeat (5) tick();
    chk("a_nacc", 64'(acc_addr.size()), 64'd2);
    chk("a_addr0", 64'(acc_addr[0]), 64'd0);
    chk("a_bc0", 64'(acc_bc[0]), 64'd16);
    chk("a_addr1", 64'(acc_addr[1]), 64'd16);
    chk("a_bc1", 64'(acc_bc[1]), 64'd4);
    chk("a_active", 64'(active_buffer), 64'd0);
    for (int p = 0; p < 40; p++) pop($sformatf("a_px%0d", p), 24'(p));
    chk("a_uflow_clean", 64'(underflow), 64'd0);
    pixel_req = 1'b1;
    tick();
    pixel_req = 1'b0;
    chk("a_tail_pvld", 64'(pixel_valid), 64'd0);
    chk("a_tail_pixel", 64'(pixel), 64'd0);
    chk("a_tail_uflow", 64'(underflow), 64'd1);
    repeat (10) tick();
    chk("a_no_more_reads", 64'(acc_addr.size()), 64'd2);

    // Swap to buffer 1 with a 5-cycle waitrequest stall on the first request
    wait_cfg = 5;
    n0  = acc_addr.size();
    rc0 = read_cycles;
    start_frame(1'b1, 1'b0);
    chk("b_swap_pulse", 64'(swap_done), 64'd1);
    chk("b_active", 64'(active_buffer), 64'd1);
    chk("b_uflow_clr", 64'(underflow), 64'd0);
    tick();
    chk("b_swap_once", 64'(swap_done), 64'd0);
    wait_acc(n0 + 1, "b_acc_timeout");
    wait_cfg = 0;
    chk("b_read_cycles", 64'(read_cycles - rc0), 64'd6);
    chk("b_stable", 64'(stall_viol), 64'd0);
    wait_beats(40, "b_beats_timeout");
    repeat (3) tick();
    chk("b_nacc", 64'(acc_addr.size()), 64'(n0 + 2));
    chk("b_addr0", 64'(acc_addr[n0]), 64'h100000);
    chk("b_addr1", 64'(acc_addr[n0 + 1]), 64'h100010);
    pop("b_px0", 24'h200000);
    pop("b_px1", 24'h200001);

    // Drain: restart the frame after 3 of 16 beats
    beat_stop = 3;
    n0 = acc_addr.size();
    start_frame(1'b0, 1'b0);
    for (int i = 0; i < 200 && !(acc_addr.size() == n0 + 1 && burst_beats == 3); i++) tick();
    chk("d_paused", 64'(burst_beats), 64'd3);
    b0 = beats_total;
    start_frame(1'b0, 1'b0);
    beat_stop = -1;
    wait_acc(n0 + 2, "d_acc_timeout");
    chk("d_new_addr", 64'(acc_addr[n0 + 1]), 64'd0);
    chk("d_after_drain", 64'(acc_cyc[n0 + 1] > last_beat_cyc), 64'd1);
    chk("d_discarded", 64'(beats_total - b0), 64'd13);
    wait_beats(b0 + 13 + 20, "d_beats_timeout");
    pop("d_px0", 24'h000000);
    pop("d_px1", 24'h000001);

    // 16 bpp expansion, 10 words in a single burst
    data16 = 1'b1;
    n0 = acc_addr.size();
    b0 = beats_total;
    start_frame(1'b0, 1'b1);
    wait_acc(n0 + 1, "e_acc_timeout");
    chk("e_bc", 64'(acc_bc[n0]), 64'd10);
    wait_beats(b0 + 10, "e_beats_timeout");
    pop("e_px0", 24'hFFFFFF);
    pop("e_px1", 24'h0000FF);
    pop("e_px2", 24'h00FF00);
    pop("e_px3", 24'hFF0000);
    pop("e_px4", 24'hFFFFFF);

    // frame_start with pixel_req: flush wins; then pop on empty FIFO
    b0 = beats_total;
    pixel_req   = 1'b1;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    chk("f_coinc_pvld", 64'(pixel_valid), 64'd0);
    chk("f_coinc_uflow", 64'(underflow), 64'd0);
    tick();
    pixel_req = 1'b0;
    chk("f_empty_pvld", 64'(pixel_valid), 64'd0);
    chk("f_empty_uflow", 64'(underflow), 64'd1);
    wait_beats(b0 + 10, "f_beats_timeout");
    pop("f_px0", 24'hFFFFFF);
    chk("f_uflow_sticky", 64'(underflow), 64'd1);
    start_frame(1'b0, 1'b1);
    chk("f_uflow_cleared", 64'(underflow), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
